// File: rtl/pe_pool_relu_mc.sv
// Multi-lane pooling/ReLU post-processor: reduces a runtime-sized window per lane
// by max or average, then requantises, optionally clamps negatives, and saturates.

module pe_pool_lane #(
  parameter int ACC_WID  = 20,
  parameter int DATA_WID = 8,
  parameter int WIN_B    = 4,
  parameter int SHIFT_B  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       take,
  input  logic                       first,
  input  logic                       close,
  input  logic                       mode,
  input  logic [SHIFT_B-1:0]         avg_shift,
  input  logic [SHIFT_B-1:0]         out_shift,
  input  logic                       relu_en,
  input  logic signed [ACC_WID-1:0]  din,
  output logic signed [DATA_WID-1:0] dout
);
  localparam int AW = ACC_WID + WIN_B;
  localparam logic signed [AW-1:0] SMAX = (AW'(1) <<< (DATA_WID - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  logic signed [AW-1:0] acc, ext, acc_nxt, v0, v1, v2;
  logic signed [DATA_WID-1:0] dsat;

  assign ext = {{WIN_B{din[ACC_WID-1]}}, din};

  always_comb begin
    acc_nxt = ext;
    if (!first) begin
      if (mode) acc_nxt = acc + ext;
      else      acc_nxt = (ext > acc) ? ext : acc;
    end
  end

  // Result is taken from acc_nxt so the closing element is included.
  always_comb begin
    v0 = mode ? (acc_nxt >>> avg_shift) : acc_nxt;
    v1 = v0 >>> out_shift;
    v2 = (relu_en && v1 < 0) ? '0 : v1;
    if (v2 > SMAX)      dsat = SMAX[DATA_WID-1:0];
    else if (v2 < SMIN) dsat = SMIN[DATA_WID-1:0];
    else                dsat = v2[DATA_WID-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (take)  acc  <= acc_nxt;
      if (close) dout <= dsat;
    end
  end
endmodule

module pe_pool_relu_mc #(
  parameter int ACC_WID  = 20,
  parameter int DATA_WID = 8,
  parameter int CH_NUM   = 4,
  parameter int WIN_B    = 4,
  parameter int SHIFT_B  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_load,
  input  logic [WIN_B-1:0]             cfg_win,
  input  logic                         cfg_mode,
  input  logic [SHIFT_B-1:0]           cfg_avg_shift,
  input  logic [SHIFT_B-1:0]           cfg_out_shift,
  input  logic                         cfg_relu_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [CH_NUM*ACC_WID-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_NUM*DATA_WID-1:0]   out_data,
  output logic [WIN_B-1:0]             out_cnt,
  output logic                         busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [1:0]         state;
  logic [WIN_B-1:0]   win_q, cnt, cnt_nxt, win_eff;
  logic               mode_q, relu_q;
  logic [SHIFT_B-1:0] avs_q, ous_q;
  logic               take, first, close;

  assign in_ready = (state != EMIT);
  assign busy     = (state != IDLE);
  assign take     = in_valid && in_ready;
  assign first    = (state == IDLE);
  assign cnt_nxt  = first ? WIN_B'(1) : cnt + WIN_B'(1);
  assign win_eff  = (win_q == '0) ? WIN_B'(1) : win_q;
  assign close    = take && ((cnt_nxt == win_eff) || in_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      win_q     <= WIN_B'(1);
      mode_q    <= 1'b0;
      avs_q     <= '0;
      ous_q     <= '0;
      relu_q    <= 1'b1;
      cnt       <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && cfg_load) begin
        win_q  <= cfg_win;
        mode_q <= cfg_mode;
        avs_q  <= cfg_avg_shift;
        ous_q  <= cfg_out_shift;
        relu_q <= cfg_relu_en;
      end
      if (take) cnt <= cnt_nxt;
      if (close) begin
        out_valid <= 1'b1;
        out_cnt   <= cnt_nxt;
      end
      case (state)
        IDLE, ACCUM: begin
          if (close)     state <= EMIT;
          else if (take) state <= ACCUM;
        end
        EMIT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    pe_pool_lane #(
      .ACC_WID(ACC_WID), .DATA_WID(DATA_WID), .WIN_B(WIN_B), .SHIFT_B(SHIFT_B)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .take     (take),
      .first    (first),
      .close    (close),
      .mode     (mode_q),
      .avg_shift(avs_q),
      .out_shift(ous_q),
      .relu_en  (relu_q),
      .din      (in_data[g*ACC_WID +: ACC_WID]),
      .dout     (out_data[g*DATA_WID +: DATA_WID])
    );
  end
endmodule
